dma_engine: RTL and testbench

DMA_ENGINE -- requirements
Module: dma_engine

---
 rtl/dma_pkg.sv | 10 +
 rtl/dma_if.sv | 34 +++
 rtl/dma_fifo.sv | 43 ++++
 rtl/dma_engine.sv | 140 ++++++++++++++
 tb/tb_dma_engine.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared FSM state encoding and transfer size constant for the DMA engine
package dma_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;
    localparam logic [2:0] SIZE_WORD = 3'd2;
endpackage

// File: rtl/dma_if.sv
// dma_if: read/write request and data handshakes between the DMA engine (master) and memory (slave)
interface dma_if #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
);
    logic                  read_request_valid;
    logic                  read_request_ready;
    logic [AXI_AWIDTH-1:0] read_request_addr;
    logic [31:0]           read_len;
    logic [2:0]            read_size;
    logic [AXI_DWIDTH-1:0] read_data;
    logic                  read_data_valid;
    logic                  read_data_ready;
    logic                  write_request_valid;
    logic                  write_request_ready;
    logic [AXI_AWIDTH-1:0] write_request_addr;
    logic [31:0]           write_len;
    logic [2:0]            write_size;
    logic [AXI_DWIDTH-1:0] write_data;
    logic                  write_data_valid;
    logic                  write_data_ready;
    modport master (
        output read_request_valid, read_request_addr, read_len, read_size, read_data_ready,
        input  read_request_ready, read_data, read_data_valid,
        output write_request_valid, write_request_addr, write_len, write_size, write_data, write_data_valid,
        input  write_request_ready, write_data_ready
    );
    modport slave (
        input  read_request_valid, read_request_addr, read_len, read_size, read_data_ready,
        output read_request_ready, read_data, read_data_valid,
        input  write_request_valid, write_request_addr, write_len, write_size, write_data, write_data_valid,
        output write_request_ready, write_data_ready
    );
endinterface

// File: rtl/dma_fifo.sv
// dma_fifo: synchronous power-of-two FIFO buffering read beats until the write side takes them
module dma_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_pop,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);
    localparam int PW = $clog2(DEPTH);
    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;
    logic              w_push;
    logic              w_pop;
    assign o_full  = r_count == (PW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = r_mem[r_rd_ptr];
    // storage and pointers; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/dma_engine.sv
// dma_engine: single-channel copy engine, read beats buffered through dma_fifo; DMA_CHECKSUM_EN adds an XOR checksum output
module dma_engine
    import dma_pkg::*;
#(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AXI_AWIDTH-1:0] src_addr,
    input  logic [AXI_AWIDTH-1:0] dst_addr,
    input  logic [31:0]           len,
    output logic                  busy,
    output logic                  done,
`ifdef DMA_CHECKSUM_EN
    output logic [AXI_DWIDTH-1:0] checksum,
`endif
    dma_if.master                 bus
);
    state_t                r_state;
    state_t                w_next;
    logic [AXI_AWIDTH-1:0] r_src;
    logic [AXI_AWIDTH-1:0] r_dst;
    logic [31:0]           r_len;
    logic [31:0]           r_rd_cnt;
    logic [31:0]           r_wr_cnt;
    logic                  r_rreq_done;
    logic                  r_wreq_done;
    logic                  w_accept;
    logic                  w_rreq_fire;
    logic                  w_wreq_fire;
    logic                  w_rd_fire;
    logic                  w_wr_fire;
    logic                  w_full;
    logic                  w_empty;
    logic [AXI_DWIDTH-1:0] w_head;
    assign w_accept    = (r_state == ST_IDLE) & start;
    assign w_rreq_fire = bus.read_request_valid & bus.read_request_ready;
    assign w_wreq_fire = bus.write_request_valid & bus.write_request_ready;
    assign w_rd_fire   = bus.read_data_valid & bus.read_data_ready;
    assign w_wr_fire   = bus.write_data_valid & bus.write_data_ready;
    assign bus.read_request_addr  = r_src;
    assign bus.write_request_addr = r_dst;
    assign bus.read_len           = r_len;
    assign bus.write_len          = r_len;
    assign bus.read_size          = SIZE_WORD;
    assign bus.write_size         = SIZE_WORD;
    assign bus.write_data         = w_head;
    dma_fifo #(
        .DWIDTH (AXI_DWIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rd_fire),
        .i_data  (bus.read_data),
        .i_pop   (w_wr_fire),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end
    // next state and handshake outputs; write_data_valid never looks at write_data_ready
    always_comb begin
        w_next                  = r_state;
        busy                    = 1'b1;
        done                    = 1'b0;
        bus.read_request_valid  = 1'b0;
        bus.write_request_valid = 1'b0;
        bus.read_data_ready     = 1'b0;
        bus.write_data_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_next = (len == 32'd0) ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                bus.read_request_valid  = ~r_rreq_done;
                bus.write_request_valid = ~r_wreq_done;
                if ((r_rreq_done | bus.read_request_ready) & (r_wreq_done | bus.write_request_ready))
                    w_next = ST_XFER;
            end
            ST_XFER: begin
                bus.read_data_ready  = ~w_full & (r_rd_cnt < r_len);
                bus.write_data_valid = ~w_empty & (r_wr_cnt < r_len);
                if (r_wr_cnt == r_len) w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end
    // captured job, request-accepted flags and beat counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_rreq_done <= 1'b0;
            r_wreq_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_src       <= src_addr;
                r_dst       <= dst_addr;
                r_len       <= len;
                r_rd_cnt    <= '0;
                r_wr_cnt    <= '0;
                r_rreq_done <= 1'b0;
                r_wreq_done <= 1'b0;
            end
            if (w_rreq_fire) r_rreq_done <= 1'b1;
            if (w_wreq_fire) r_wreq_done <= 1'b1;
            if (w_rd_fire) r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_wr_fire) r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end
`ifdef DMA_CHECKSUM_EN
    logic [AXI_DWIDTH-1:0] r_checksum;
    assign checksum = r_checksum;
    // running XOR of every beat written out, restarted by each accepted start
    always_ff @(posedge clk) begin
        if (rst)            r_checksum <= '0;
        else if (w_accept)  r_checksum <= '0;
        else if (w_wr_fire) r_checksum <= r_checksum ^ w_head;
    end
`endif
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: randomized memory responder with an in-order copy reference model for dma_engine
module tb_dma_engine;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 8;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [31:0]   len = '0;
    logic          busy;
    logic          done;
`ifdef DMA_CHECKSUM_EN
    logic [DW-1:0] checksum;
    logic [DW-1:0] cs_at_done;
`endif
    dma_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) bus ();
    dma_engine #(
        .AXI_AWIDTH (AW),
        .AXI_DWIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
`ifdef DMA_CHECKSUM_EN
        .checksum (checksum),
`endif
        .bus      (bus)
    );
    always #5 clk = ~clk;
    int            n_checks = 0;
    int            n_pass = 0;
    int            p_rq = 100;
    int            p_rv = 100;
    int            p_wr = 100;
    bit            stall_w = 1'b0;
    logic [DW-1:0] src_mem [64];
    logic [DW-1:0] got [$];
    int            cur_len = 0;
    bit            rd_active = 1'b0;
    int            rd_idx = 0;
    int            reads_cnt = 0;
    int            done_cnt = 0;
    int            req_seen = 0;
    logic [AW-1:0] rq_addr, wq_addr;
    logic [31:0]   rq_len, wq_len;
    logic [2:0]    rq_size, wq_size;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask
    // memory responder: drive at negedge, record handshakes that will fire on the next posedge
    initial begin
        bus.read_request_ready  = 1'b0;
        bus.write_request_ready = 1'b0;
        bus.read_data_valid     = 1'b0;
        bus.read_data           = '0;
        bus.write_data_ready    = 1'b0;
        forever begin
            @(negedge clk);
            bus.read_request_ready  = $urandom_range(99) < p_rq;
            bus.write_request_ready = $urandom_range(99) < p_rq;
            bus.read_data_valid     = rd_active && rd_idx < cur_len && $urandom_range(99) < p_rv;
            bus.read_data           = (rd_active && rd_idx < cur_len) ? src_mem[rd_idx] : '0;
            bus.write_data_ready    = !stall_w && $urandom_range(99) < p_wr;
            #1;
            if (!rst) begin
                if (bus.read_request_valid || bus.write_request_valid) req_seen++;
                if (bus.read_request_valid && bus.read_request_ready) begin
                    rd_active = 1'b1;
                    rd_idx    = 0;
                    rq_addr   = bus.read_request_addr;
                    rq_len    = bus.read_len;
                    rq_size   = bus.read_size;
                end
                if (bus.write_request_valid && bus.write_request_ready) begin
                    wq_addr = bus.write_request_addr;
                    wq_len  = bus.write_len;
                    wq_size = bus.write_size;
                end
                if (bus.read_data_valid && bus.read_data_ready) begin
                    rd_idx++;
                    reads_cnt++;
                end
                if (bus.write_data_valid && bus.write_data_ready) got.push_back(bus.write_data);
                if (done) begin
                    done_cnt++;
`ifdef DMA_CHECKSUM_EN
                    cs_at_done = checksum;
`endif
                end
            end
        end
    end
    task automatic fill();
        for (int i = 0; i < 64; i++) src_mem[i] = $urandom;
    endtask
    task automatic run_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
        got.delete();
        rd_active = 1'b0;
        rd_idx    = 0;
        reads_cnt = 0;
        done_cnt  = 0;
        req_seen  = 0;
        cur_len   = n;
        rq_addr = '1; wq_addr = '1; rq_len = '1; wq_len = '1; rq_size = '1; wq_size = '1;
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask
    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        chk({tag, "_done_seen"}, done_cnt != 0, 1);
        @(posedge clk); #2;
    endtask
    task automatic check_xfer(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
        logic [DW-1:0] x = '0;
        chk({tag, "_nwords"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) chk({tag, "_word"}, got[i], src_mem[i]);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_rq_addr"}, rq_addr, s);
        chk({tag, "_wq_addr"}, wq_addr, d);
        chk({tag, "_rq_len"}, rq_len, n);
        chk({tag, "_wq_len"}, wq_len, n);
        chk({tag, "_rq_size"}, rq_size, 2);
        chk({tag, "_wq_size"}, wq_size, 2);
        for (int i = 0; i < n; i++) x ^= src_mem[i];
`ifdef DMA_CHECKSUM_EN
        chk({tag, "_checksum"}, cs_at_done, x);
`endif
    endtask
    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rreq_v"}, bus.read_request_valid, 0);
        chk({tag, "_wreq_v"}, bus.write_request_valid, 0);
        chk({tag, "_rd_rdy"}, bus.read_data_ready, 0);
        chk({tag, "_wd_v"}, bus.write_data_valid, 0);
    endtask
    initial begin
        int n;
        logic [AW-1:0] s, d;
        repeat (3) @(posedge clk);
        #2;
        chk_idle_outputs("reset");
        chk("reset_raddr", bus.read_request_addr, 0);
        chk("reset_wlen", bus.write_len, 0);
        rst = 1'b0;
        @(posedge clk); #2;
        fill();
        run_start(32'h100, 32'h400, 4);
        wait_done("basic", 200);
        check_xfer("basic", 32'h100, 32'h400, 4);
        fill();
        stall_w = 1'b1;
        run_start(32'h2000, 32'h3000, 20);
        repeat (30) @(posedge clk);
        #2;
        chk("stall_reads", reads_cnt, DEPTH);
        chk("stall_rd_rdy", bus.read_data_ready, 0);
        chk("stall_writes", got.size(), 0);
        stall_w = 1'b0;
        wait_done("stall", 500);
        check_xfer("stall", 32'h2000, 32'h3000, 20);
        run_start(32'h10, 32'h20, 0);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 1);
        @(posedge clk); #2;
        chk("len0_done_drop", done, 0);
        chk("len0_busy_drop", busy, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("len0_no_req", req_seen, 0);
        chk("len0_pulses", done_cnt, 1);
        fill();
        p_wr = 50;
        run_start(32'h500, 32'h600, 6);
        n = 0;
        while (!(bus.read_data_ready || bus.write_data_valid) && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("ign_in_xfer", bus.read_data_ready || bus.write_data_valid, 1);
        src_addr = 32'hDEAD0000;
        dst_addr = 32'hBEEF0000;
        len      = 3;
        start    = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        chk("ign_raddr", bus.read_request_addr, 32'h500);
        chk("ign_waddr", bus.write_request_addr, 32'h600);
        chk("ign_rlen", bus.read_len, 6);
        chk("ign_wlen", bus.write_len, 6);
        wait_done("ign", 500);
        check_xfer("ign", 32'h500, 32'h600, 6);
        repeat (3) @(posedge clk);
        #2;
        chk("ign_stays_idle", busy, 0);
        p_wr = 100;
        fill();
        run_start(32'h700, 32'h800, 10);
        n = 0;
        while (got.size() < 3 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("rst_mid_3beats", got.size(), 3);
        rst = 1'b1;
        rd_active = 1'b0;
        @(posedge clk); #2;
        chk_idle_outputs("rst_mid");
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("rst_mid_no_done", done_cnt, 0);
        chk("rst_mid_idle", busy, 0);
        fill();
        run_start(32'h900, 32'hA00, 2);
        wait_done("after_rst", 200);
        check_xfer("after_rst", 32'h900, 32'hA00, 2);
`ifdef DMA_CHECKSUM_EN
        src_mem[0] = 32'h1;
        src_mem[1] = 32'h2;
        src_mem[2] = 32'h4;
        src_mem[3] = 32'h8;
        run_start(32'h40, 32'h80, 4);
        wait_done("cs", 200);
        chk("cs_value", cs_at_done, 32'hF);
`endif
        for (int k = 0; k < 6; k++) begin
            p_rq = $urandom_range(100, 30);
            p_rv = $urandom_range(100, 30);
            p_wr = $urandom_range(100, 30);
            n = $urandom_range(16, 1);
            s = $urandom & 32'hFFFF_FFFC;
            d = $urandom & 32'hFFFF_FFFC;
            fill();
            run_start(s, d, n);
            wait_done("rand", 2000);
            check_xfer("rand", s, d, n);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
